onehot_event_encoder: RTL and testbench
=======================================

ONEHOT_EVENT_ENCODER -- requirements
Module: onehot_event_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Parameters (one per line: name, default, meaning):
  N_LINES, 8, number of event lines; fixed at 8 in this release
  CODE_W, 3, output code width, equal to log2(N_LINES)
REQ-003 Ports (name, direction, width, meaning):
  clk         in   1  clock
  rst         in   1  synchronous active-high reset
  ev_in       in   8  event lines from the 3-to-8 decoder stage; any bit pattern legal
  code        out  3  index of granted event line
  code_valid  out  1  code holds a valid index
  code_ready  in   1  consumer accepts code this cycle
  pending     out  8  registered pending-event vector
  drop_cnt    out  8  saturating count of cycles with a lost event

Function
REQ-004 Pending register: on each edge, pending <= (pending & ~clr_mask) | ev_in; clr_mask is the one-hot index granted that cycle, or 0 if none.
REQ-005 Set/clear collision: when ev_in sets the bit being cleared in the same cycle, the bit SHALL remain 1 (new event retained).
REQ-006 Output holder FSM states are EMPTY and FULL; reset state is EMPTY.
REQ-007 EMPTY -> FULL when pending != 0: grant one index k, load code <= k, clear pending[k].
REQ-008 FULL with code_valid & code_ready and pending != 0: stay FULL, load the next grant in the same cycle, giving zero-bubble back-to-back output.
REQ-009 FULL with code_valid & code_ready and pending == 0: -> EMPTY.
REQ-010 FULL with code_ready = 0: code and code_valid SHALL hold stable; no grant occurs.
REQ-011 code_valid SHALL equal (state == FULL).
REQ-012 Arbitration: round-robin over pending, searching from index ptr upward and wrapping 7 -> 0; the first set bit wins.
REQ-013 After granting index k, ptr <= (k + 1) mod 8; ptr is unchanged on cycles with no grant.
REQ-014 Latency: an ev_in bit high before edge E is in pending after E; if the holder can load, code_valid is high after edge E+1 (2 cycles, input to output).
REQ-015 A lost event is an ev_in bit that is high while its pending bit is already 1 and is not cleared that cycle.
REQ-016 drop_cnt SHALL increment by 1 on any cycle with at least one lost event, regardless of how many bits are lost, and SHALL saturate at 255.
REQ-017 ev_in = 0 with pending = 0 SHALL leave all state unchanged.

Reset
REQ-018 While rst = 1 on an edge: pending = 0, ptr = 0, state = EMPTY, code = 0, code_valid = 0, drop_cnt = 0; ev_in is ignored on that edge.
REQ-019 Reset asserted mid-transfer (FULL, not yet accepted) SHALL discard the held code with no partial handshake; code_valid is 0 after the reset edge.
REQ-020 The first grant after reset deassertion SHALL start the search at index 0.

Structure
REQ-021 A shared package onehot_pkg SHALL hold N_LINES, CODE_W and the EMPTY/FULL state encodings.
REQ-022 Round-robin selection SHALL be a combinational sub-module rr_pick8 with inputs req[7:0] and ptr[2:0] and outputs gnt_idx[2:0] and gnt_any; the top level holds all registers.

Verification
REQ-023 Single event: after reset, ev_in = 8'h10 for 1 cycle with code_ready = 1 -> code_valid high 2 cycles later for 1 cycle, code = 3'd4, then pending = 0.
REQ-024 Round-robin fairness: ev_in = 8'h81 pulsed, ptr = 0, code_ready = 1 -> codes 0 then 7 on consecutive cycles; ptr ends at 0 (wrap).
REQ-025 Back-pressure: ev_in = 8'h06, code_ready = 0 for 5 cycles -> code = 1 held stable with code_valid = 1; on release -> 1, then 2 back-to-back.
REQ-026 Drop and saturation: code_ready = 0, ev_in = 8'h01 held for 300 cycles -> drop_cnt = 255 (saturated); pending[0] = 1.
REQ-027 Set/clear collision: pending[3] granted while ev_in[3] = 1 in the same cycle -> pending[3] stays 1; code 3 is emitted twice; drop_cnt unchanged.
REQ-028 Reset mid-operation: state FULL with code = 5 and pending = 8'hF0, assert rst for 1 cycle -> code_valid = 0, pending = 0, drop_cnt = 0; the next event 8'h20 yields code 5.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared constants for the one-hot event encoder.
// Line count, code width and output holder state encodings.
package onehot_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/onehot_event_encoder_rr_pick8.sv
// Combinational round-robin picker over eight request lines.
// The search starts at ptr and wraps from 7 back to 0.
module rr_pick8
  import onehot_pkg::*;
(
  input  logic [N_LINES-1:0] req,
  input  logic [CODE_W-1:0]  ptr,
  output logic [CODE_W-1:0]  gnt_idx,
  output logic               gnt_any
);

  logic [CODE_W-1:0] idx;

  // Walk offsets high to low so the nearest set bit wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      idx = ptr + CODE_W'(i);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_event_encoder.sv
// Latches event lines into a pending vector and emits their
// indices one at a time through a valid/ready output holder.
module onehot_event_encoder
  import onehot_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LINES-1:0]  ev_in,
  output logic [CODE_W-1:0]   code,
  output logic                code_valid,
  input  logic                code_ready,
  output logic [N_LINES-1:0]  pending,
  output logic [7:0]          drop_cnt
);

  logic [0:0]         state;
  logic [CODE_W-1:0]  ptr;
  logic [CODE_W-1:0]  gnt_idx;
  logic               gnt_any;
  logic               can_load;
  logic               grant;
  logic [N_LINES-1:0] clr_mask;
  logic               lost;

  rr_pick8 u_pick (
    .req     (pending),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign code_valid = (state == ST_FULL);
  assign can_load   = (state == ST_EMPTY) | code_ready;
  assign grant      = can_load & gnt_any;
  assign clr_mask   = grant ? (N_LINES'(1) << gnt_idx) : '0;

  // A set on a bit being cleared this cycle is a fresh event, not a loss.
  assign lost = |(ev_in & pending & ~clr_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      ptr      <= '0;
      state    <= ST_EMPTY;
      code     <= '0;
      drop_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | ev_in;
      if (lost && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (grant) begin
        state <= ST_FULL;
        code  <= gnt_idx;
        ptr   <= gnt_idx + CODE_W'(1);
      end else if (state == ST_FULL && code_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_onehot_event_encoder.sv
// Randomized and directed bench for onehot_event_encoder,
// checked every cycle against a behavioural event-queue model.
module tb_onehot_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ev_in;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] pending;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit [7:0] m_pend;
  int       m_ptr;
  bit       m_full;
  int       m_code;
  int       m_drop;

  onehot_event_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .ev_in      (ev_in),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pending    (pending),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit [7:0] ev, input bit rdy, input bit r);
    bit       found;
    int       k;
    bit [7:0] clr;
    if (r) begin
      m_pend = 0; m_ptr = 0; m_full = 0; m_code = 0; m_drop = 0;
      return;
    end
    found = 0;
    k = 0;
    if (!m_full || rdy) begin
      for (int d = 0; d < 8; d++) begin
        if (!found && m_pend[(m_ptr + d) % 8]) begin
          found = 1;
          k = (m_ptr + d) % 8;
        end
      end
    end
    clr = found ? 8'(1 << k) : 8'h00;
    if ((ev & m_pend & ~clr) != 0 && m_drop < 255)
      m_drop++;
    m_pend = (m_pend & ~clr) | ev;
    if (found) begin
      m_full = 1;
      m_code = k;
      m_ptr  = (k + 1) % 8;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
  endtask

  task automatic cyc(input bit [7:0] ev, input bit rdy, input bit r);
    ev_in      = ev;
    code_ready = rdy;
    rst        = r;
    @(posedge clk);
    model_step(ev, rdy, r);
    #1;
    check("m_valid", int'(code_valid), int'(m_full));
    check("m_code", int'(code), m_code);
    check("m_pend", int'(pending), int'(m_pend));
    check("m_drop", int'(drop_cnt), m_drop);
  endtask

  initial begin
    bit [7:0] ev;
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'hFF, 1'b1, 1'b1);
    check("rst_valid", int'(code_valid), 0);
    check("rst_pend", int'(pending), 0);
    check("rst_drop", int'(drop_cnt), 0);
    check("rst_code", int'(code), 0);

    // single event, two-cycle latency
    cyc(8'h10, 1'b1, 1'b0);
    check("single_lat1", int'(code_valid), 0);
    cyc(8'h00, 1'b1, 1'b0);
    check("single_valid", int'(code_valid), 1);
    check("single_code", int'(code), 4);
    check("single_pend", int'(pending), 0);
    cyc(8'h00, 1'b1, 1'b0);
    check("single_done", int'(code_valid), 0);

    // round-robin wrap; ptr was advanced to 5 by the single event
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h81, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    check("rr_first", int'(code), 0);
    cyc(8'h00, 1'b1, 1'b0);
    check("rr_second", int'(code), 7);
    check("rr_second_v", int'(code_valid), 1);
    cyc(8'h81, 1'b1, 1'b0);
    check("rr_empty", int'(code_valid), 0);
    cyc(8'h00, 1'b1, 1'b0);
    check("rr_wrap", int'(code), 0);
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);

    // back-pressure hold then back-to-back release
    cyc(8'h06, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, 1'b0, 1'b0);
      check("bp_hold_code", int'(code), 1);
      check("bp_hold_valid", int'(code_valid), 1);
    end
    cyc(8'h00, 1'b1, 1'b0);
    check("bp_next", int'(code), 2);
    check("bp_next_v", int'(code_valid), 1);
    cyc(8'h00, 1'b1, 1'b0);
    check("bp_drain", int'(code_valid), 0);

    // drop counter saturation
    for (int i = 0; i < 300; i++)
      cyc(8'h01, 1'b0, 1'b0);
    check("sat_drop", int'(drop_cnt), 255);
    check("sat_pend0", int'(pending[0]), 1);

    // set/clear collision
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h08, 1'b1, 1'b0);
    cyc(8'h08, 1'b1, 1'b0);
    check("col_pend", int'(pending), 8'h08);
    check("col_code1", int'(code), 3);
    cyc(8'h00, 1'b1, 1'b0);
    check("col_code2", int'(code), 3);
    check("col_valid2", int'(code_valid), 1);
    check("col_drop", int'(drop_cnt), 0);
    cyc(8'h00, 1'b1, 1'b0);

    // reset mid-transfer
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h20, 1'b0, 1'b0);
    cyc(8'hF0, 1'b0, 1'b0);
    check("mid_code", int'(code), 5);
    check("mid_pend", int'(pending), 8'hF0);
    cyc(8'h00, 1'b0, 1'b1);
    check("mid_rst_v", int'(code_valid), 0);
    check("mid_rst_p", int'(pending), 0);
    check("mid_rst_d", int'(drop_cnt), 0);
    cyc(8'h20, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    check("mid_after", int'(code), 5);
    check("mid_after_v", int'(code_valid), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ev = 8'($urandom);
      if ($urandom_range(0, 3) != 0)
        ev = ev & 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        ev = 8'h00;
      cyc(ev, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
